alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational datapath ALU.
- Keeps the existing 4-bit opcode map and adds logic ops, C/V flags, and iterative multi-cycle shifts.
- Uses a valid/ready handshake on input and output, so it can sit between the register-read stage and the writeback stage of the pipelined CPU.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- SAW, $clog2(WIDTH), derived localparam: shift-amount width, taken from B[SAW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts operation this cycle
- opcode  in  4  operation select
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B / shift amount
- out_valid  out  1  OUT and flags valid
- out_ready  in  1  consumer takes result
- OUT  out  WIDTH  registered result
- Z  out  1  zero flag
- N  out  1  negative flag
- C  out  1  carry flag
- V  out  1  signed-overflow flag

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high (rst).
- Reset values:
  - OUT = 0; Z, N, C, V = 0.
  - out_valid = 0; state = IDLE.
  - An in-flight shift or multiply is discarded; no output appears for it.
- State machine: IDLE, ITER, HOLD.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready; operands and opcode are latched.
- Opcodes:
  - 0001 ADD: A+B
  - 0111 SUB: A-B
  - 0101 INC: A+1
  - 0110 NOT: ~A
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 1000 SHL, 1001 SHR (logical), 1010 SRA: shift A by B[SAW-1:0]
- Single-cycle ops (all except shifts and MUL):
  - Result is registered on the transfer edge; out_valid = 1 on the next cycle. Latency is 1.
- Shifts:
  - Amount 0: behaves as a single-cycle op with OUT = A.
  - Otherwise: IDLE -> ITER, one bit per cycle, downcounter = amount.
  - When the counter reaches 0 the result is registered, out_valid = 1, and state -> HOLD if out_ready = 0, else IDLE.
  - Latency = amount + 1 cycles.
- HOLD/out_valid: OUT and flags stay stable while out_valid && !out_ready. out_valid clears on the handshake cycle unless a new single-cycle result lands in the same cycle (back-to-back throughput of 1/cycle).
- Undefined opcodes:
  - OUT keeps its previous value; Z, N, C, V unchanged.
  - out_valid still pulses with latency 1, so the handshake never stalls.
- Flags (registered with OUT):
  - Z = (result == 0).
  - N = result[WIDTH-1] (two's-complement sign).
  - C = carry-out of bit WIDTH-1 for ADD/INC; C = NOT borrow for SUB (A >= B unsigned gives 1); C = last bit shifted out for shifts; C = 0 for logic ops.
  - V = signed overflow for ADD/SUB/INC; V = 0 otherwise.
- Wrap-around:
  - INC of all-ones gives 0, Z = 1, C = 1.
  - INC of 0x7FF..F gives V = 1, N = 1.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Opcode 1011 = MUL, the low WIDTH bits of A*B via iterative shift-add in ITER, WIDTH iterations.
  - Latency WIDTH + 1.
  - Z and N from the result; C = 1 if any discarded high product bit is nonzero (unsigned); V = 0.
- Undefined: 1011 follows the undefined-opcode rule. No multiplier datapath is synthesised.

Test Plan:
- WIDTH = 32, ADD 0x7FFFFFFF + 1 -> one cycle later out_valid = 1, OUT = 0x80000000, N = 1, V = 1, C = 0, Z = 0.
- SUB 5 - 5, then SUB 3 - 5 on back-to-back cycles with out_ready = 1 -> OUT = 0 (Z = 1, C = 1), then OUT = 0xFFFFFFFE (N = 1, C = 0); in_ready stays high.
- SHL A = 0x1, B = 4 -> in_ready low for 4 cycles, out_valid at cycle 5, OUT = 0x10; SRA A = 0x80000000, B = 31 -> OUT = 0xFFFFFFFF, C = 0.
- out_ready = 0 with a held result OUT = 0x3 -> OUT/flags stable for 10 cycles, in_ready = 0; out_ready = 1 -> handshake completes, in_ready returns to 1.
- Assert rst during SHL with B = 20 at iteration 7 -> OUT = 0, out_valid = 0 immediately (asynchronous); the next op after release completes normally.
- ALU_MUL_EN defined: MUL 0x10000 * 0x10000 -> after 33 cycles OUT = 0, Z = 1, C = 1. Undefined: opcode 1011 -> OUT holds the prior value, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake on input and output.
// Single-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifts.
// Optional iterative shift-add multiplier (opcode 1011) when ALU_MUL_EN is
// defined; without it, 1011 behaves like any other undefined opcode.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] OUT,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int SAW = $clog2(WIDTH);
    // Counter is one bit wider than the shift amount so it can hold WIDTH.
    localparam int CW  = SAW + 1;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_INC = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_step;
`endif

    logic [WIDTH:0]   add_full, sub_full, inc_full;
    logic [CW-1:0]    shamt;
    logic             transfer;
    logic             ld;
    logic [WIDTH-1:0] ld_res;
    logic             ld_c, ld_v;
    logic [WIDTH-1:0] step_acc;
    logic             step_c;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign transfer  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign OUT       = out_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;

    assign add_full = {1'b0, A} + {1'b0, B};
    // A + ~B + 1: the carry out is the inverted borrow (1 when A >= B).
    assign sub_full = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    assign inc_full = {1'b0, A} + (WIDTH+1)'(1);
    assign shamt    = {1'b0, B[SAW-1:0]};

    // One iteration step of the latched shift (or multiply) operation.
    always_comb begin
        step_acc = acc_q;
        step_c   = 1'b0;
`ifdef ALU_MUL_EN
        // {hi,acc} is the partial product; acc starts as the multiplier and
        // is consumed from the LSB while product bits shift in at the top.
        mul_sum  = {1'b0, hi_q} + {1'b0, (acc_q[0] ? opa_q : {WIDTH{1'b0}})};
        hi_step  = hi_q;
`endif
        case (op_q)
            OP_SHL: begin
                step_acc = {acc_q[WIDTH-2:0], 1'b0};
                step_c   = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                step_acc = {1'b0, acc_q[WIDTH-1:1]};
                step_c   = acc_q[0];
            end
            OP_SRA: begin
                step_acc = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_c   = acc_q[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                step_acc = {mul_sum[0], acc_q[WIDTH-1:1]};
                hi_step  = mul_sum[WIDTH:1];
                step_c   = |mul_sum[WIDTH:1];
            end
`endif
            default: ;
        endcase
    end

    // Next-state, result and flag computation for the FSM.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        out_valid_d = out_valid_q && !out_ready;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
`ifdef ALU_MUL_EN
        hi_d        = hi_q;
        opa_d       = opa_q;
`endif
        ld          = 1'b0;
        ld_res      = '0;
        ld_c        = 1'b0;
        ld_v        = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    case (opcode)
                        OP_ADD: begin
                            ld     = 1'b1;
                            ld_res = add_full[WIDTH-1:0];
                            ld_c   = add_full[WIDTH];
                            ld_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                                     (add_full[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_SUB: begin
                            ld     = 1'b1;
                            ld_res = sub_full[WIDTH-1:0];
                            ld_c   = sub_full[WIDTH];
                            ld_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                                     (sub_full[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_INC: begin
                            ld     = 1'b1;
                            ld_res = inc_full[WIDTH-1:0];
                            ld_c   = inc_full[WIDTH];
                            ld_v   = !A[WIDTH-1] && inc_full[WIDTH-1];
                        end
                        OP_NOT: begin
                            ld     = 1'b1;
                            ld_res = ~A;
                        end
                        OP_AND: begin
                            ld     = 1'b1;
                            ld_res = A & B;
                        end
                        OP_OR: begin
                            ld     = 1'b1;
                            ld_res = A | B;
                        end
                        OP_XOR: begin
                            ld     = 1'b1;
                            ld_res = A ^ B;
                        end
                        OP_SHL, OP_SHR, OP_SRA: begin
                            if (shamt == '0) begin
                                ld     = 1'b1;
                                ld_res = A;
                            end else begin
                                acc_d   = A;
                                cnt_d   = shamt;
                                op_d    = opcode;
                                state_d = ITER;
                            end
                        end
`ifdef ALU_MUL_EN
                        OP_MUL: begin
                            acc_d   = B;
                            hi_d    = '0;
                            opa_d   = A;
                            cnt_d   = CW'(WIDTH);
                            op_d    = opcode;
                            state_d = ITER;
                        end
`endif
                        // Undefined opcode: result and flags untouched, but
                        // still answer so the producer never stalls.
                        default: out_valid_d = 1'b1;
                    endcase
                end
            end
            ITER: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
`ifdef ALU_MUL_EN
                hi_d  = hi_step;
`endif
                if (cnt_q == CW'(1)) begin
                    ld      = 1'b1;
                    ld_res  = step_acc;
                    ld_c    = step_c;
                    state_d = out_ready ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            out_d       = ld_res;
            z_d         = (ld_res == '0);
            n_d         = ld_res[WIDTH-1];
            c_d         = ld_c;
            v_d         = ld_v;
            out_valid_d = 1'b1;
        end
    end

    // State and output registers; reset discards any in-flight iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
`ifdef ALU_MUL_EN
            hi_q        <= '0;
            opa_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
`ifdef ALU_MUL_EN
            hi_q        <= hi_d;
            opa_q       <= opa_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH = 32): directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   opcode = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] OUT;
    logic         Z, N, C, V;

    int vectors = 0;
    int miscompares = 0;

    // Reference model's view of the currently presented result.
    logic [W-1:0] m_out = '0;
    logic         m_z = 1'b0, m_n = 1'b0, m_c = 1'b0, m_v = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .OUT       (OUT),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V)
    );

    always #5 clk = ~clk;

    // Updates the model result for a defined op; returns expected latency.
    function automatic int model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          r;
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned u;
        int              amt = int'(b[4:0]);
        bit              ok = 1'b1;
        int              lat = 1;
        logic [W-1:0]    res = '0;
        logic            c = 1'b0, v = 1'b0;
        case (op)
            4'b0001: begin
                u = ua + ub; res = u[W-1:0]; c = u[W];
                r = sa + sb; v = (r > SMAX) || (r < SMIN);
            end
            4'b0111: begin
                res = a - b; c = (a >= b);
                r = sa - sb; v = (r > SMAX) || (r < SMIN);
            end
            4'b0101: begin
                res = a + 1; c = (a == '1);
                r = sa + 1; v = (r > SMAX);
            end
            4'b0110: res = ~a;
            4'b0010: res = a & b;
            4'b0011: res = a | b;
            4'b0100: res = a ^ b;
            4'b1000: begin
                res = a << amt; lat = amt + 1;
                c = (amt == 0) ? 1'b0 : a[W-amt];
            end
            4'b1001: begin
                res = a >> amt; lat = amt + 1;
                c = (amt == 0) ? 1'b0 : a[amt-1];
            end
            4'b1010: begin
                res = $signed(a) >>> amt; lat = amt + 1;
                c = (amt == 0) ? 1'b0 : a[amt-1];
            end
`ifdef ALU_MUL_EN
            4'b1011: begin
                u = ua * ub; res = u[W-1:0]; c = (u[63:32] != 0); lat = W + 1;
            end
`endif
            default: ok = 1'b0;
        endcase
        if (ok) begin
            m_out = res; m_z = (res == '0); m_n = res[W-1]; m_c = c; m_v = v;
        end
        return lat;
    endfunction

    // Offers one op, waits (bounded) for acceptance and then for out_valid.
    // obs_lat = -1 if the op was never accepted.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int obs_lat, output int exp_lat);
        int guard = 0;
        exp_lat = model(op, a, b);
        opcode = op; A = a; B = b; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0; obs_lat = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        obs_lat = 1;
        while (!out_valid && obs_lat < 100) begin
            @(posedge clk); #1; obs_lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({OUT, Z, N, C, V, out_valid} !== {{W{1'b0}}, 5'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got OUT=%h ZNCV=%b%b%b%b ov=%b, expected all zero",
                     OUT, Z, N, C, V, out_valid);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add_overflow();
        int ol, el;
        issue(4'b0001, 32'h7FFF_FFFF, 32'h1, ol, el);
        vectors++;
        if (ol !== 1) begin
            miscompares++;
            $display("FAIL add_latency: got %0d expected 1", ol);
        end
        vectors++;
        if ({OUT, Z, N, C, V} !== {32'h8000_0000, 4'b0101}) begin
            miscompares++;
            $display("FAIL add_ovf: got OUT=%h ZNCV=%b%b%b%b expected OUT=80000000 ZNCV=0101",
                     OUT, Z, N, C, V);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        opcode = 4'b0111; A = 32'd5; B = 32'd5; in_valid = 1'b1;
        void'(model(4'b0111, 32'd5, 32'd5));
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, in_ready, OUT, Z, N, C, V} !== {2'b11, 32'h0, 4'b1010}) begin
            miscompares++;
            $display("FAIL sub_eq: got ov=%b ir=%b OUT=%h ZNCV=%b%b%b%b expected ov=1 ir=1 OUT=0 ZNCV=1010",
                     out_valid, in_ready, OUT, Z, N, C, V);
        end
        A = 32'd3; B = 32'd5;
        void'(model(4'b0111, 32'd3, 32'd5));
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, in_ready, OUT, Z, N, C, V} !== {2'b11, 32'hFFFF_FFFE, 4'b0100}) begin
            miscompares++;
            $display("FAIL sub_neg: got ov=%b ir=%b OUT=%h ZNCV=%b%b%b%b expected ov=1 ir=1 OUT=fffffffe ZNCV=0100",
                     out_valid, in_ready, OUT, Z, N, C, V);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_shifts();
        int cnt, low, ol, el;
        @(posedge clk); #1;
        opcode = 4'b1000; A = 32'h1; B = 32'd4; in_valid = 1'b1;
        void'(model(4'b1000, 32'h1, 32'd4));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1; low = 0;
        while (!out_valid && cnt < 100) begin
            if (!in_ready) low++;
            @(posedge clk); #1; cnt++;
        end
        vectors++;
        if (cnt !== 5 || low !== 4) begin
            miscompares++;
            $display("FAIL shl_timing: got latency=%0d ready_low=%0d expected 5 and 4", cnt, low);
        end
        vectors++;
        if (OUT !== 32'h10 || C !== 1'b0) begin
            miscompares++;
            $display("FAIL shl_result: got OUT=%h C=%b expected 00000010 C=0", OUT, C);
        end
        issue(4'b1010, 32'h8000_0000, 32'd31, ol, el);
        vectors++;
        if (ol !== 32 || OUT !== 32'hFFFF_FFFF || C !== 1'b0 || N !== 1'b1) begin
            miscompares++;
            $display("FAIL sra31: got lat=%0d OUT=%h C=%b N=%b expected lat=32 OUT=ffffffff C=0 N=1",
                     ol, OUT, C, N);
        end
        issue(4'b1001, 32'h1234_5678, 32'd0, ol, el);
        vectors++;
        if (ol !== 1 || OUT !== 32'h1234_5678 || C !== 1'b0) begin
            miscompares++;
            $display("FAIL shr0: got lat=%0d OUT=%h C=%b expected lat=1 OUT=12345678 C=0", ol, OUT, C);
        end
    endtask

    task automatic test_hold();
        int ol, el, bad;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'b0011, 32'h1, 32'h2, ol, el);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({out_valid, in_ready, OUT, Z, N, C, V} !== {2'b10, 32'h3, 4'b0000}) bad++;
        end
        vectors++;
        if (bad !== 0 || ol !== 1) begin
            miscompares++;
            $display("FAIL hold_stable: got %0d unstable cycles lat=%0d expected 0 and 1", bad, ol);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_drain: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
        end
        // Shift completing into a stalled consumer parks in HOLD.
        out_ready = 1'b0;
        issue(4'b1001, 32'h84, 32'd3, ol, el);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if ({out_valid, in_ready, OUT, Z, N, C, V} !== {2'b10, 32'h10, 4'b0010}) bad++;
        end
        vectors++;
        if (bad !== 0 || ol !== 4) begin
            miscompares++;
            $display("FAIL shift_hold: got %0d unstable cycles lat=%0d expected 0 and 4", bad, ol);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_hold_drain: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int ol, el;
        bit seen;
        logic [W-1:0] a, b;
        @(posedge clk); #1;
        opcode = 4'b1000; A = 32'h3; B = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({OUT, Z, N, C, V, out_valid} !== {{W{1'b0}}, 5'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got OUT=%h ZNCV=%b%b%b%b ov=%b expected all zero",
                     OUT, Z, N, C, V, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_out = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL discarded_shift: got stray out_valid=1 expected none");
        end
        a = $urandom; b = $urandom;
        issue(4'b0100, a, b, ol, el);
        vectors++;
        if (ol !== el || {OUT, Z, N, C, V} !== {m_out, m_z, m_n, m_c, m_v}) begin
            miscompares++;
            $display("FAIL post_reset_op: got lat=%0d OUT=%h expected lat=%0d OUT=%h",
                     ol, OUT, el, m_out);
        end
    endtask

    task automatic test_mul_or_undef();
        int ol, el;
`ifdef ALU_MUL_EN
        issue(4'b1011, 32'h0001_0000, 32'h0001_0000, ol, el);
        vectors++;
        if (ol !== 33 || {OUT, Z, N, C, V} !== {32'h0, 4'b1010}) begin
            miscompares++;
            $display("FAIL mul_wrap: got lat=%0d OUT=%h ZNCV=%b%b%b%b expected lat=33 OUT=0 ZNCV=1010",
                     ol, OUT, Z, N, C, V);
        end
`else
        issue(4'b0001, 32'h1234, 32'h1, ol, el);
        issue(4'b1011, $urandom, $urandom, ol, el);
        vectors++;
        if (ol !== 1 || {OUT, Z, N, C, V} !== {32'h1235, 4'b0000}) begin
            miscompares++;
            $display("FAIL undef_1011: got lat=%0d OUT=%h ZNCV=%b%b%b%b expected lat=1 OUT=00001235 ZNCV=0000",
                     ol, OUT, Z, N, C, V);
        end
`endif
        // INC wrap-around sets Z and C, then opcode 0000 must leave both alone.
        issue(4'b0101, 32'hFFFF_FFFF, 32'h0, ol, el);
        issue(4'b0000, $urandom, $urandom, ol, el);
        vectors++;
        if (ol !== 1 || {OUT, Z, N, C, V} !== {32'h0, 4'b1010}) begin
            miscompares++;
            $display("FAIL undef_0000: got lat=%0d OUT=%h ZNCV=%b%b%b%b expected lat=1 OUT=0 ZNCV=1010",
                     ol, OUT, Z, N, C, V);
        end
    endtask

    task automatic test_random();
        int ol, el;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] corner [5];
        corner[0] = '0; corner[1] = '1; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h1;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            issue(op, a, b, ol, el);
            vectors++;
            if (ol !== el || {OUT, Z, N, C, V} !== {m_out, m_z, m_n, m_c, m_v}) begin
                miscompares++;
                $display("FAIL random op=%b A=%h B=%h: got lat=%0d OUT=%h ZNCV=%b%b%b%b expected lat=%0d OUT=%h ZNCV=%b%b%b%b",
                         op, a, b, ol, OUT, Z, N, C, V, el, m_out, m_z, m_n, m_c, m_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_shifts();
        test_hold();
        test_reset_mid_shift();
        test_mul_or_undef();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
